// File: rtl/gpio_mm_responder.sv
// Memory-mapped GPIO responder: CTRL drives the output pins and holds the interrupt enables.
// STAT returns debounced inputs and sticky change flags; each flag raises a level interrupt when enabled.
module gpio_mm_responder #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEBOUNCE_DIV = 1000,
    parameter logic [15:0] OUT_RESET    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Select,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       AddrIn,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic              irq
);

    localparam int unsigned CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_DIV - 1);

    typedef enum logic [1:0] {
        REG_NONE = 2'b00,
        REG_CTRL = 2'b01,
        REG_STAT = 2'b10,
        REG_RSVD = 2'b11
    } reg_sel_e;

    reg_sel_e                  reg_sel;
    logic                      wr_ctrl, wr_stat, tick;
    logic [WIDTH-1:0]          clr_mask;

    logic [WIDTH-1:0]          out_q, out_d;
    logic [WIDTH-1:0]          irq_en_q, irq_en_d;
    logic [WIDTH-1:0]          flag_q, flag_d;
    logic                      irq_q, irq_d;
    logic [WIDTH-1:0]          sync1_q, sync2_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0][2:0]     hist_q, hist_d;
    logic [WIDTH-1:0]          db_q, db_d;
    logic [31:0]               ctrl_rd, stat_rd;

    // Only AddrIn[3:2] is decoded; the remaining address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{AddrIn[31:4], AddrIn[1:0]};

    assign reg_sel  = reg_sel_e'(AddrIn[3:2]);
    assign wr_ctrl  = Select && MemWrite && (reg_sel == REG_CTRL);
    assign wr_stat  = Select && MemWrite && (reg_sel == REG_STAT);
    assign clr_mask = wr_stat ? DataIn[16 +: WIDTH] : '0;
    assign tick     = (cnt_q == CNT_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            out_d    = DataIn[WIDTH-1:0];
            irq_en_d = DataIn[16 +: WIDTH];
        end

        cnt_d = tick ? '0 : cnt_q + CW'(1);

        hist_d = hist_q;
        db_d   = db_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (tick) hist_d[i] = {hist_q[i][1:0], sync2_q[i]};
            if (hist_d[i] == 3'b111)      db_d[i] = 1'b1;
            else if (hist_d[i] == 3'b000) db_d[i] = 1'b0;
        end

        // A db transition on the same edge as a write-1-to-clear keeps the flag set.
        flag_d = (flag_q & ~clr_mask) | (db_d ^ db_q);
        irq_d  = |(flag_q & irq_en_q);
    end

    always_comb begin
        ctrl_rd = '0;
        stat_rd = '0;
        ctrl_rd[WIDTH-1:0]  = out_q;
        ctrl_rd[16 +: WIDTH] = irq_en_q;
        stat_rd[WIDTH-1:0]  = db_q;
        stat_rd[16 +: WIDTH] = flag_q;

        DataOut = '0;
        if (Select && MemRead) begin
            case (reg_sel)
                REG_CTRL: DataOut = ctrl_rd;
                REG_STAT: DataOut = stat_rd;
                default:  DataOut = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= OUT_RESET[WIDTH-1:0];
            irq_en_q <= '0;
            flag_q   <= '0;
            irq_q    <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            hist_q   <= '0;
            db_q     <= '0;
        end else begin
            out_q    <= out_d;
            irq_en_q <= irq_en_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            db_q     <= db_d;
        end
    end

    assign gpio_out = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_mm_responder.sv
// Directed bench for gpio_mm_responder with DEBOUNCE_DIV=4; debounce timing is predicted from a
// free-running phase counter that restarts at 0 on every reset edge.
module tb_gpio_mm_responder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIV   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Select, MemRead, MemWrite;
    logic [31:0]       AddrIn, DataIn, DataOut;
    logic [WIDTH-1:0]  gpio_in, gpio_out;
    logic              irq;

    int checks   = 0;
    int failures = 0;
    int ph;

    gpio_mm_responder #(
        .WIDTH(WIDTH),
        .DEBOUNCE_DIV(DIV),
        .OUT_RESET(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Select(Select),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .AddrIn(AddrIn),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Prescaler phase: the value the counter holds going into the next edge (tick when 3).
    always @(posedge clk) begin
        if (!rst_n) ph <= 0;
        else        ph <= (ph == int'(DIV) - 1) ? 0 : ph + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Select = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        AddrIn = 32'h0; DataIn = 32'h0;
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        Select = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        AddrIn = addr; DataIn = 32'h0;
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Select = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
        AddrIn = addr; DataIn = data;
        step();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  lat;
        bit  found;

        rst_n = 1'b0;
        gpio_in = '0;
        idle();
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state
        rd(32'h1001_0024);
        check("rst_ctrl", DataOut, 32'h0000_0000);
        check("rst_out", {16'h0, gpio_out}, 32'h0000_0000);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(32'h1001_0028);
        check("rst_stat", DataOut, 32'h0000_0000);

        // Write CTRL with a concurrent read: the read returns pre-write contents
        Select = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        AddrIn = 32'h1001_0024; DataIn = 32'h0001_A5A5;
        #1;
        check("rw_old", DataOut, 32'h0000_0000);
        step();
        idle();
        check("out_wr", {16'h0, gpio_out}, 32'h0000_A5A5);
        rd(32'h1001_0024);
        check("ctrl_rd", DataOut, 32'h0001_A5A5);

        // Strobes without chip select are ignored
        Select = 1'b0; MemRead = 1'b1; MemWrite = 1'b1;
        AddrIn = 32'h1001_0024; DataIn = 32'hFFFF_FFFF;
        #1;
        check("nosel_rd", DataOut, 32'h0000_0000);
        step();
        idle();
        check("nosel_out", {16'h0, gpio_out}, 32'h0000_A5A5);
        rd(32'h1001_0024);
        check("nosel_ctrl", DataOut, 32'h0001_A5A5);

        // A 5-cycle glitch spans at most two ticks, so db never fills
        idle();
        gpio_in[0] = 1'b1;
        repeat (5) step();
        gpio_in[0] = 1'b0;
        repeat (16) step();
        rd(32'h1001_0028);
        check("glitch_stat", DataOut, 32'h0000_0000);
        check("glitch_irq", {31'h0, irq}, 32'h0);

        // Steady high: db rises within 2 + 3*4 = 14 cycles, at least 11
        gpio_in[0] = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (DataOut[0] === 1'b1) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
        check("rise_found", {31'h0, found}, 32'h1);
        check("rise_lat_ok", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        check("rise_stat", DataOut, 32'h0001_0001);
        check("rise_irq0", {31'h0, irq}, 32'h0);
        step();
        check("rise_irq1", {31'h0, irq}, 32'h1);

        // Write-1-to-clear: flag clears at the write edge, irq follows one cycle later
        wr(32'h1001_0028, 32'h0001_0000);
        rd(32'h1001_0028);
        check("clr_stat", DataOut, 32'h0000_0001);
        check("clr_irq_hold", {31'h0, irq}, 32'h1);
        step();
        check("clr_irq_drop", {31'h0, irq}, 32'h0);

        // Clear issued on the very edge db falls: the set wins
        idle();
        gpio_in[0] = 1'b0;
        step();
        step();
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ph == int'(DIV) - 1) begin
                n++;
                if (n == 3) begin
                    found = 1'b1;
                    break;
                end
            end
            step();
        end
        check("coll_found", {31'h0, found}, 32'h1);
        rd(32'h1001_0028);
        check("coll_pre", DataOut, 32'h0000_0001);
        wr(32'h1001_0028, 32'h0001_0000);
        rd(32'h1001_0028);
        check("coll_stat", DataOut, 32'h0001_0000);
        step();
        check("coll_irq", {31'h0, irq}, 32'h1);

        // Unmapped offsets: reads return 0, writes change nothing
        Select = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        AddrIn = 32'h1001_002C; DataIn = 32'hFFFF_FFFF;
        #1;
        check("rsv_rd", DataOut, 32'h0000_0000);
        step();
        idle();
        rd(32'h1001_0020);
        check("rsv0_rd", DataOut, 32'h0000_0000);
        rd(32'h1001_0024);
        check("rsv_ctrl", DataOut, 32'h0001_A5A5);
        rd(32'h1001_0028);
        check("rsv_stat", DataOut, 32'h0001_0000);
        check("rsv_out", {16'h0, gpio_out}, 32'h0000_A5A5);

        // Reset mid-debounce: all state returns to reset values, history and phase restart
        idle();
        gpio_in[0] = 1'b1;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd(32'h1001_0024);
        check("rst2_ctrl", DataOut, 32'h0000_0000);
        check("rst2_out", {16'h0, gpio_out}, 32'h0000_0000);
        check("rst2_irq", {31'h0, irq}, 32'h0);
        rd(32'h1001_0028);
        check("rst2_stat", DataOut, 32'h0000_0000);
        // sync2 high after edge 2, ticks at edges 4, 8, 12 -> db rises at edge 12
        repeat (11) step();
        check("rst2_e11", DataOut, 32'h0000_0000);
        step();
        check("rst2_e12", DataOut, 32'h0001_0001);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
